button_count_ctrl: RTL

// - Turns debounced button levels (up/down/clear) into count steps for a 4-digit BCD counter shown on the 7-segment display.
// - Single press gives one step. Holding a button gives auto-repeat after a hold delay. Clear zeroes the count.
// - Sits between the three Debouncer instances and the 7-segment display multiplexer. Owns the count register.

---
 rtl/count_pkg.sv | 23 ++
 rtl/bcd_step_unit.sv | 45 ++++
 rtl/button_count_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the button-driven BCD counter: FSM encoding,
// digit width and default timing parameters.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10,
        LOCK   = 2'b11
    } state_t;

    localparam int BCD_W            = 4;
    localparam int DEF_TICK_BITS    = 19;
    localparam int DEF_HOLD_TICKS   = 50;
    localparam int DEF_REPEAT_TICKS = 10;
    localparam int DEF_DIGITS       = 4;

    // Hold/repeat counter must reach the larger of the two limits.
    function automatic int cnt_width(input int hold_ticks, input int repeat_ticks);
        return $clog2((hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks) + 1;
    endfunction

endpackage

// File: rtl/bcd_step_unit.sv
// Combinational multi-digit BCD increment/decrement; wrap flags the
// all-9 -> all-0 (up) or all-0 -> all-9 (down) roll-over.
module bcd_step_unit
    import count_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic [BCD_W*DIGITS-1:0] bcd_in,
    input  logic                    up,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    wrap
);

    logic             carry;
    logic [BCD_W-1:0] digit;

    always_comb begin
        bcd_out = bcd_in;
        carry   = 1'b1;
        digit   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = bcd_in[i*BCD_W +: BCD_W];
            if (carry) begin
                if (up) begin
                    if (digit == BCD_W'(9)) begin
                        bcd_out[i*BCD_W +: BCD_W] = '0;
                    end else begin
                        bcd_out[i*BCD_W +: BCD_W] = digit + BCD_W'(1);
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == '0) begin
                        bcd_out[i*BCD_W +: BCD_W] = BCD_W'(9);
                    end else begin
                        bcd_out[i*BCD_W +: BCD_W] = digit - BCD_W'(1);
                        carry = 1'b0;
                    end
                end
            end
        end
        // Carry/borrow surviving past the top digit means the count rolled over.
        wrap = carry;
    end

endmodule

// File: rtl/button_count_ctrl.sv
// Turns debounced up/down/clear levels into single steps and hold-to-repeat
// steps of a BCD count register driving the 7-segment display.
module button_count_ctrl
    import count_pkg::*;
#(
    parameter int TICK_BITS    = DEF_TICK_BITS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int DIGITS       = DEF_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    db_up,
    input  logic                    db_down,
    input  logic                    db_clr,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    step,
    output logic                    wrap,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(HOLD_TICKS, REPEAT_TICKS);

    logic [TICK_BITS-1:0]    tick_cnt;
    logic                    tick;
    logic                    hist_up, hist_down, hist_clr;
    logic                    up_rise, down_rise, clr_rise;
    state_t                  state, state_nxt;
    logic                    dir_up, dir_up_nxt;
    logic [CNT_W-1:0]        hr_cnt, hr_cnt_nxt, hr_cnt_inc;
    logic                    do_step, do_clr, step_up;
    logic                    active, other_rise;
    logic [BCD_W*DIGITS-1:0] bcd_stepped;
    logic                    step_wrap;

    assign tick       = (tick_cnt == '0);
    assign up_rise    = db_up & ~hist_up;
    assign down_rise  = db_down & ~hist_down;
    assign clr_rise   = db_clr & ~hist_clr;
    assign active     = dir_up ? db_up : db_down;
    assign other_rise = dir_up ? down_rise : up_rise;
    assign hr_cnt_inc = hr_cnt + CNT_W'(1);
    assign busy       = (state != IDLE);

    bcd_step_unit #(.DIGITS(DIGITS)) u_step (
        .bcd_in  (bcd),
        .up      (step_up),
        .bcd_out (bcd_stepped),
        .wrap    (step_wrap)
    );

    always_comb begin
        state_nxt  = state;
        dir_up_nxt = dir_up;
        hr_cnt_nxt = hr_cnt;
        do_step    = 1'b0;
        do_clr     = 1'b0;
        step_up    = dir_up;
        // Clear overrides everything; still-held buttons need a fresh press.
        if (clr_rise) begin
            do_clr     = 1'b1;
            state_nxt  = IDLE;
            hr_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (up_rise || down_rise) begin
                        if (db_up && db_down) begin
                            state_nxt = LOCK;
                        end else begin
                            do_step    = 1'b1;
                            step_up    = up_rise;
                            dir_up_nxt = up_rise;
                            state_nxt  = HOLD;
                            hr_cnt_nxt = '0;
                        end
                    end
                end
                HOLD, REPEAT: begin
                    if (!active) begin
                        state_nxt = IDLE;
                    end else if (other_rise) begin
                        state_nxt = LOCK;
                    end else if (tick) begin
                        if (hr_cnt_inc == ((state == HOLD) ? CNT_W'(HOLD_TICKS)
                                                           : CNT_W'(REPEAT_TICKS))) begin
                            do_step    = 1'b1;
                            state_nxt  = REPEAT;
                            hr_cnt_nxt = '0;
                        end else begin
                            hr_cnt_nxt = hr_cnt_inc;
                        end
                    end
                end
                LOCK: begin
                    if (!db_up && !db_down) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // History regs reset high so a button held through reset needs a release first.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            hist_up   <= 1'b1;
            hist_down <= 1'b1;
            hist_clr  <= 1'b1;
            state     <= IDLE;
            dir_up    <= 1'b1;
            hr_cnt    <= '0;
            bcd       <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            tick_cnt  <= tick_cnt + TICK_BITS'(1);
            hist_up   <= db_up;
            hist_down <= db_down;
            hist_clr  <= db_clr;
            state     <= state_nxt;
            dir_up    <= dir_up_nxt;
            hr_cnt    <= hr_cnt_nxt;
            step      <= do_step;
            wrap      <= do_step & step_wrap;
            if (do_clr)       bcd <= '0;
            else if (do_step) bcd <= bcd_stepped;
        end
    end

endmodule
